// File: rtl/instr_issue.sv
// Instruction FIFO, legality filter and issue sequencer for the control FSM.
// Holds the head entry stable from issue until control reports completion.
module instr_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        w,
  input  logic [2:0]  nsel,
  output logic        s,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  reg_num,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        busy,
  output logic [7:0]  illegal_cnt,
  output logic [15:0] retired_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC
  } state_t;

  state_t      state_q;
  logic        s_q;
  logic [7:0]  ill_q;
  logic [15:0] ret_q;

  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        legal;
  logic [15:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign head = empty ? 16'h0000 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    legal = 1'b0;
    case (head[15:11])
      5'b110_10,
      5'b110_00,
      5'b101_00,
      5'b101_01,
      5'b101_10,
      5'b101_11: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  // Illegal heads drain from IDLE; legal ones leave only at end of EXEC.
  assign pop = ((state_q == IDLE) && !empty && !legal) ||
               ((state_q == EXEC) && w);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      ill_q   <= 8'h00;
      ret_q   <= 16'h0000;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            if (!legal) begin
              if (ill_q != 8'hFF) ill_q <= ill_q + 8'd1;
            end else if (w) begin
              state_q <= ISSUE;
              s_q     <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w) begin
            state_q <= EXEC;
            s_q     <= 1'b0;
          end
        end
        EXEC: begin
          if (w) begin
            state_q <= IDLE;
            ret_q   <= ret_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          s_q     <= 1'b0;
        end
      endcase
    end
  end

  assign s           = s_q;
  assign illegal_cnt = ill_q;
  assign retired_cnt = ret_q;
  assign busy        = !empty || (state_q != IDLE);

  assign opcode = head[15:13];
  assign op     = head[12:11];
  assign shift  = head[4:3];
  assign sximm8 = {{8{head[7]}}, head[7:0]};
  assign sximm5 = {{11{head[4]}}, head[4:0]};

  always_comb begin
    reg_num = 3'b000;
    case (nsel)
      3'b100:  reg_num = head[10:8];
      3'b010:  reg_num = head[7:5];
      3'b001:  reg_num = head[2:0];
      default: reg_num = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed pushes, a behavioural control model
// and a scoreboard checked whenever s rises.
module tb_instr_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        w;
  logic [2:0]  nsel;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  reg_num;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        busy;
  logic [7:0]  illegal_cnt;
  logic [15:0] retired_cnt;

  instr_issue #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .w           (w),
    .nsel        (nsel),
    .s           (s),
    .opcode      (opcode),
    .op          (op),
    .reg_num     (reg_num),
    .shift       (shift),
    .sximm8      (sximm8),
    .sximm5      (sximm5),
    .busy        (busy),
    .illegal_cnt (illegal_cnt),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [41:0] sb [$];
  bit          stall = 1'b0;
  int          cnt   = 0;
  logic        s_d;
  logic        w_d;

  task automatic chk(input string nm, input logic [41:0] act,
                     input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [15:0] x);
    case (x[15:11])
      5'b11010, 5'b11000, 5'b10100,
      5'b10101, 5'b10110, 5'b10111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exec_len(input logic [4:0] oo);
    case (oo)
      5'b11010: return 2;
      5'b10100, 5'b10110: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [41:0] exp_of(input logic [15:0] x);
    logic [15:0] i8;
    logic [15:0] i5;
    i8 = {{8{x[7]}}, x[7:0]};
    i5 = {{11{x[4]}}, x[4:0]};
    return {x[15:13], x[12:11], x[4:3], i8, i5, x[10:8]};
  endfunction

  // Behavioural control: leaves wait at the edge ending ISSUE.
  initial begin
    logic       sn;
    logic       wn;
    logic [4:0] oo;
    forever begin
      @(negedge clk);
      sn = s;
      wn = w;
      oo = {opcode, op};
      @(posedge clk);
      #1;
      if (!reset_n) begin
        cnt = 0;
      end else if (cnt > 0) begin
        if (!stall) begin
          cnt--;
          if (cnt == 0) w = 1'b1;
        end
      end else if (sn && wn) begin
        cnt = exec_len(oo);
        w   = 1'b0;
      end
    end
  end

  // Monitor: every rising s must match the oldest pushed legal instruction.
  always @(negedge clk) begin
    if (!reset_n) begin
      s_d = 1'b0;
      w_d = 1'b0;
    end else begin
      if (s && !s_d) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_s act=1 exp=0");
        end else begin
          chk("issue_fields",
              {opcode, op, shift, sximm8, sximm5, reg_num},
              sb.pop_front());
        end
      end
      if (s_d && w_d) chk("s_one_cycle", 42'(s), 42'(0));
      s_d = s;
      w_d = w;
    end
  end

  task automatic push(input logic [15:0] x);
    int b;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = x;
    b = 0;
    while (!in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout act=0 exp=1");
      in_valid = 1'b0;
      return;
    end
    if (is_legal(x)) sb.push_back(exp_of(x));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clk);
    while (busy && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout act=1 exp=0");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    w        = 1'b0;
    nsel     = 3'b100;
    #12;
    chk("rst_s", 42'(s), 42'(0));
    chk("rst_busy", 42'(busy), 42'(0));
    chk("rst_ready", 42'(in_ready), 42'(1));
    chk("rst_cnts", 42'({illegal_cnt, retired_cnt}), 42'(0));
    chk("rst_dec", {opcode, op, shift, sximm8, sximm5, reg_num}, 42'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Legal head with w=0 in IDLE must not issue.
    push(16'hA2B3);
    repeat (6) begin
      @(negedge clk);
      chk("s_idle_w0", 42'(s), 42'(0));
    end
    chk("busy_head", 42'(busy), 42'(1));
    nsel = 3'b010;
    #1 chk("rn_rd", 42'(reg_num), 42'(5));
    nsel = 3'b001;
    #1 chk("rn_rm", 42'(reg_num), 42'(3));
    nsel = 3'b011;
    #1 chk("rn_bad", 42'(reg_num), 42'(0));
    nsel = 3'b100;
    #1 chk("rn_rn", 42'(reg_num), 42'(2));
    w = 1'b1;
    wait_idle();
    chk("ret1", 42'(retired_cnt), 42'(1));

    push(16'hD205);
    wait_idle();
    chk("ret_mov", 42'(retired_cnt), 42'(2));

    push(16'hD080);
    push(16'hA150);
    wait_idle();
    chk("ret_neg", 42'(retired_cnt), 42'(4));

    push(16'hE000);
    push(16'hA000);
    wait_idle();
    chk("ill1", 42'(illegal_cnt), 42'(1));
    chk("ret_ill", 42'(retired_cnt), 42'(5));

    // Backpressure with control stalled in its non-wait states.
    stall = 1'b1;
    push(16'hD201);
    repeat (4) @(negedge clk);
    push(16'hC0E4);
    chk("full_ready", 42'(in_ready), 42'(0));
    fork
      push(16'hB8C5);
    join_none
    repeat (5) @(negedge clk);
    chk("full_hold", 42'(in_ready), 42'(0));
    chk("full_busy", 42'(busy), 42'(1));
    stall = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();
    chk("ret_bp", 42'(retired_cnt), 42'(8));

    repeat (256) push(16'hE000);
    wait_idle();
    chk("ill_sat", 42'(illegal_cnt), 42'(255));
    chk("ret_sat", 42'(retired_cnt), 42'(8));

    // Reset in the middle of EXEC with a push pending.
    push(16'hA000);
    b = 0;
    while (!s && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("s_seen", 42'(s), 42'(1));
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_instr = 16'hD205;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_s", 42'(s), 42'(0));
    chk("mid_rst_busy", 42'(busy), 42'(0));
    chk("mid_rst_ready", 42'(in_ready), 42'(1));
    chk("mid_rst_cnts", 42'({illegal_cnt, retired_cnt}), 42'(0));
    chk("mid_rst_dec", {opcode, op, shift, sximm8, sximm5, reg_num}, 42'(0));
    in_valid = 1'b0;
    w = 1'b1;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ret", 42'(retired_cnt), 42'(0));
    chk("post_rst_ready", 42'(in_ready), 42'(1));
    chk("post_rst_busy", 42'(busy), 42'(0));

    // Retire counter wrap from a preloaded 0xFFFF.
    force dut.ret_q = 16'hFFFF;
    @(negedge clk);
    release dut.ret_q;
    @(negedge clk);
    chk("ret_pre", 42'(retired_cnt), 42'(16'hFFFF));
    push(16'hD205);
    wait_idle();
    chk("ret_wrap", 42'(retired_cnt), 42'(0));
    chk("sb_empty", 42'(sb.size()), 42'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
